// File: rtl/multiplier_control.sv
// Sequencer for the 8x8 signed shift-add multiplier: issues one datapath strobe per
// cycle from the multiplier LSB and closes the last partial product with a subtract.
module multiplier_control #(
  parameter int N_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear_load,
  input  logic M,
  output logic clear_A_load_B_sig,
  output logic add_sig,
  output logic sub_sig,
  output logic shift_sig,
  output logic busy,
  output logic done
);

  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    clear_A_load_B_sig = 1'b0;
    add_sig            = 1'b0;
    sub_sig            = 1'b0;
    shift_sig          = 1'b0;
    case (state)
      IDLE: begin
        if (clear_load) begin
          clear_A_load_B_sig = 1'b1;
        end else if (run) begin
          cnt_nxt   = '0;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (M) begin
          // The MSB of a two's-complement multiplier carries negative weight.
          if (cnt == LAST) sub_sig = 1'b1;
          else             add_sig = 1'b1;
          state_nxt = SHIFT;
        end else begin
          shift_sig = 1'b1;
          if (cnt == LAST) state_nxt = DONE;
          else             cnt_nxt   = cnt + 1'b1;
        end
      end
      SHIFT: begin
        shift_sig = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = EXEC;
        end
      end
      DONE: begin
        // Holding run keeps us here so a level-held start cannot retrigger.
        if (clear_load) begin
          clear_A_load_B_sig = 1'b1;
          state_nxt          = IDLE;
        end else if (!run) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == EXEC) || (state == SHIFT);
  assign done = (state == DONE);

endmodule
